flash_test_seq: RTL

Parametrised flash self-test sequencer that runs erase, program and read-verify operations over a configurable number of sectors. It repeats read-verify passes a programmable number of times, or indefinitely. It sits between the top-level test control and the existing erase/program/read engines and drives each engine with a one-cycle go pulse. Completion is taken from each engine's busy level. Compared with the earlier fixed controller, it adds a sector loop, selectable mode, pass counting, busy timeout and read-error capture.

---
 rtl/flash_test_seq_if.sv | 10 +
 rtl/flash_test_seq.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/flash_test_seq_if.sv
// flash_test_seq_if: handshake between the self-test sequencer and the erase/program/read engines
//   master (sequencer): erase_go, prog_go, read_go, sector out; erasing, proging, reading, read_err in
//   slave  (engines)  : the same signals with directions reversed
interface flash_test_seq_if #(parameter int SECT_W = 4);
  logic erase_go, prog_go, read_go;
  logic erasing, proging, reading, read_err;
  logic [SECT_W-1:0] sector;
  modport master(output erase_go, prog_go, read_go, sector, input erasing, proging, reading, read_err);
  modport slave(input erase_go, prog_go, read_go, sector, output erasing, proging, reading, read_err);
endinterface

// File: rtl/flash_test_seq.sv
// flash_test_seq: flash self-test sequencer running erase/program/read-verify over a sector loop
//   CLK50M, RST      clock and synchronous active-high reset
//   start/mode/loops request, op selection and pass total (0 = endless)
//   eng              engine handshake (go pulses, sector, busy levels, read_err)
//   state, pass_cnt  progress; done/fail/timeout/err_sect final status
module flash_test_seq #(
  parameter int NUM_SECT = 4,
  parameter int SECT_W = 4,
  parameter int LOOP_W = 8,
  parameter logic [23:0] TO_MAX = 24'd5_000_000
) (
  input  logic              CLK50M,
  input  logic              RST,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [LOOP_W-1:0] loops,
  flash_test_seq_if.master  eng,
  output logic [2:0]        state,
  output logic [LOOP_W-1:0] pass_cnt,
  output logic              done,
  output logic              fail,
  output logic              timeout,
  output logic [SECT_W-1:0] err_sect
);
  typedef enum logic [2:0] {IDLE, ERASE, PROG, READ, STOP, DONE, FAIL} st_e;
  st_e st, st_n, ent;
  logic arm, arm_n, first, first_n, tmo_n, do_ent, busy, last, to_hit;
  logic [1:0] md, md_n;
  logic [LOOP_W-1:0] lp, lp_n, pc_n, pc_inc;
  logic [SECT_W-1:0] sec, sec_n, es_n;
  logic [23:0] cnt, cnt_n;
  logic [2:0] go, go_n;
  function automatic st_e op1(input logic [1:0] m);
    return m == 2'b01 ? READ : m == 2'b11 ? PROG : ERASE;
  endfunction
  assign busy = st == ERASE ? eng.erasing : st == PROG ? eng.proging : eng.reading;
  assign last = sec == SECT_W'(NUM_SECT - 1);
  assign to_hit = cnt == TO_MAX - 24'd1;
  assign pc_inc = pass_cnt + LOOP_W'(1);
  assign state = st;
  assign done = st == DONE;
  assign fail = st == FAIL;
  assign eng.erase_go = go[0];
  assign eng.prog_go = go[1];
  assign eng.read_go = go[2];
  assign eng.sector = sec;
  always_comb begin
    st_n = st;
    arm_n = arm;
    first_n = first;
    md_n = md;
    lp_n = lp;
    pc_n = pass_cnt;
    sec_n = sec;
    es_n = err_sect;
    tmo_n = timeout;
    cnt_n = cnt;
    go_n = '0;
    ent = READ;
    do_ent = 1'b0;
    case (st)
      IDLE, DONE, FAIL: if (start) begin
        md_n = mode;
        lp_n = loops;
        first_n = 1'b1;
        pc_n = '0;
        sec_n = '0;
        tmo_n = 1'b0;
        do_ent = 1'b1;
        ent = op1(mode);
      end
      ERASE, PROG, READ:
        // busy is ignored on the go cycle so a level left over from a previous op cannot arm us
        if (arm ? (go == 3'b000 && busy) : !busy) begin
          if (arm) begin
            arm_n = 1'b0;
            cnt_n = '0;
          end else if (st == ERASE) begin
            do_ent = 1'b1;
            ent = md == 2'b00 ? PROG : READ;
          end else if (st == PROG) begin
            do_ent = 1'b1;
          end else if (eng.read_err) begin
            st_n = FAIL;
            tmo_n = 1'b0;
            es_n = sec;
          end else if (last) begin
            st_n = STOP;
          end else begin
            sec_n = sec + SECT_W'(1);
            do_ent = 1'b1;
            ent = first ? op1(md) : READ;
          end
        end else if (to_hit) begin
          st_n = FAIL;
          tmo_n = 1'b1;
          es_n = sec;
        end else begin
          cnt_n = cnt + 24'd1;
        end
      STOP: begin
        pc_n = pc_inc;
        sec_n = '0;
        first_n = 1'b0;
        if (lp != '0 && pc_inc == lp) st_n = DONE;
        else do_ent = 1'b1;
      end
      default: st_n = IDLE;
    endcase
    if (do_ent) begin
      st_n = ent;
      arm_n = 1'b1;
      cnt_n = '0;
      go_n = {ent == READ, ent == PROG, ent == ERASE};
    end
  end
  always_ff @(posedge CLK50M) begin
    if (RST) begin
      st <= IDLE;
      arm <= 1'b0;
      first <= 1'b0;
      md <= '0;
      lp <= '0;
      pass_cnt <= '0;
      sec <= '0;
      err_sect <= '0;
      timeout <= 1'b0;
      cnt <= '0;
      go <= '0;
    end else begin
      st <= st_n;
      arm <= arm_n;
      first <= first_n;
      md <= md_n;
      lp <= lp_n;
      pass_cnt <= pc_n;
      sec <= sec_n;
      err_sect <= es_n;
      timeout <= tmo_n;
      cnt <= cnt_n;
      go <= go_n;
    end
  end
endmodule
